// File: rtl/lfsr_ranged_rng.sv
// Fibonacci XNOR LFSR (3..16 bits) with a rejection-sampling draw FSM that returns values in 0..RANGE-1.
// Optional build macro LFSR_EXCLUDE_EN adds EXCLUDE_VAL, a value the draw must never return.
`timescale 1ns/1ps

module lfsr_ranged_rng #(
    parameter int NUM_BITS  = 8,
    parameter int OUT_BITS  = 8,
    parameter int RANGE     = 160,
    parameter int MAX_TRIES = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                SEED_LOAD,
    input  logic [NUM_BITS-1:0] SEED_IN,
    input  logic                REQ,
`ifdef LFSR_EXCLUDE_EN
    input  logic [OUT_BITS-1:0] EXCLUDE_VAL,
`endif
    output logic                BUSY,
    output logic                DONE,
    output logic [OUT_BITS-1:0] VALUE,
    output logic [NUM_BITS-1:0] RAND_OUT
);

    // Candidate arithmetic is done 17 bits wide so RANGE == 2^16 still compares correctly.
    localparam int CW = 17;
    localparam logic [CW-1:0] RANGE_C  = CW'(RANGE);
    localparam logic [7:0]    LAST_TRY = 8'(MAX_TRIES - 1);

    // Bit n-1 set for each 1-based tap n.
    function automatic logic [15:0] tap_mask(input int n);
        case (n)
            3:       tap_mask = 16'h0006;
            4:       tap_mask = 16'h000C;
            5:       tap_mask = 16'h0014;
            6:       tap_mask = 16'h0030;
            7:       tap_mask = 16'h0060;
            8:       tap_mask = 16'h00B8;
            9:       tap_mask = 16'h0110;
            10:      tap_mask = 16'h0240;
            11:      tap_mask = 16'h0500;
            12:      tap_mask = 16'h0829;
            13:      tap_mask = 16'h100D;
            14:      tap_mask = 16'h2015;
            15:      tap_mask = 16'h6000;
            16:      tap_mask = 16'hD008;
            default: tap_mask = 16'h0000;
        endcase
    endfunction

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

    generate
        if (NUM_BITS < 3 || NUM_BITS > 16) begin : g_bad_num_bits
            $error("lfsr_ranged_rng: NUM_BITS must be 3..16");
        end
        if (RANGE < 2 || RANGE > (1 << NUM_BITS) || 2 * RANGE < (1 << NUM_BITS)) begin : g_bad_range
            $error("lfsr_ranged_rng: RANGE outside legal bounds for NUM_BITS");
        end
        if (OUT_BITS < 1 || OUT_BITS > 16 || (1 << OUT_BITS) < RANGE) begin : g_bad_out_bits
            $error("lfsr_ranged_rng: OUT_BITS too narrow for RANGE");
        end
        if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
            $error("lfsr_ranged_rng: MAX_TRIES must be 1..255");
        end
    endgenerate

    typedef enum logic {IDLE, DRAW} state_t;

    state_t                state_q, state_d;
    logic [NUM_BITS-1:0]   lfsr_q, lfsr_d;
    logic [7:0]            try_q, try_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [OUT_BITS-1:0]   value_q, value_d;

    logic                  feedback;
    logic [CW-1:0]         cand;
    logic                  accept;
    logic [CW-1:0]         fallback;

    always_comb begin
        feedback = ~^(lfsr_q & TAPS);
        cand     = CW'(lfsr_q);
`ifdef LFSR_EXCLUDE_EN
        accept   = (cand < RANGE_C) && (cand != CW'(EXCLUDE_VAL));
        // An excluded in-range candidate can reach the last try, so only subtract when out of range.
        fallback = (cand < RANGE_C) ? cand : (cand - RANGE_C);
        if (fallback == CW'(EXCLUDE_VAL)) begin
            fallback = (fallback + CW'(1) == RANGE_C) ? '0 : (fallback + CW'(1));
        end
`else
        accept   = (cand < RANGE_C);
        fallback = cand - RANGE_C;
`endif
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        try_d   = try_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        value_d = value_q;

        if (SEED_LOAD) begin
            lfsr_d = (SEED_IN == '1) ? '0 : SEED_IN;
        end else if (ENABLE || state_q == DRAW) begin
            lfsr_d = {lfsr_q[NUM_BITS-2:0], feedback};
        end

        case (state_q)
            IDLE: begin
                if (REQ) begin
                    state_d = DRAW;
                    busy_d  = 1'b1;
                    try_d   = '0;
                end
            end
            DRAW: begin
                // A seed load stalls the draw for a cycle so the new seed becomes the next candidate.
                if (!SEED_LOAD) begin
                    if (accept) begin
                        value_d = OUT_BITS'(cand);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (try_q == LAST_TRY) begin
                        value_d = OUT_BITS'(fallback);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        try_d = try_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            try_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            try_q   <= try_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign VALUE    = value_q;
    assign RAND_OUT = lfsr_q;

endmodule

// File: tb/tb_lfsr_ranged_rng.sv
// Randomized bench for lfsr_ranged_rng: two instances (MAX_TRIES=16 and MAX_TRIES=1) share stimulus
// and are checked against a sequence-level model of the LFSR and of the draw outcome.
`timescale 1ns/1ps

module tb_lfsr_ranged_rng;

    localparam int RNG = 160;
    localparam int MT0 = 16;
    localparam int MT1 = 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       SEED_LOAD = 1'b0;
    logic [7:0] SEED_IN = 8'h00;
    logic       REQ = 1'b0;

    logic       busy0, done0, busy1, done1;
    logic [7:0] value0, rand0, value1, rand1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m0, m1;
    int prev_v0 = 0, prev_v1 = 0;
    int last_v0 = 0, last_v1 = 0;

    always #5 CLK = ~CLK;

    lfsr_ranged_rng #(.NUM_BITS(8), .OUT_BITS(8), .RANGE(RNG), .MAX_TRIES(MT0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SEED_LOAD(SEED_LOAD), .SEED_IN(SEED_IN),
        .REQ(REQ), .BUSY(busy0), .DONE(done0), .VALUE(value0), .RAND_OUT(rand0)
    );

    lfsr_ranged_rng #(.NUM_BITS(8), .OUT_BITS(8), .RANGE(RNG), .MAX_TRIES(MT1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SEED_LOAD(SEED_LOAD), .SEED_IN(SEED_IN),
        .REQ(REQ), .BUSY(busy1), .DONE(done1), .VALUE(value1), .RAND_OUT(rand1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Next state from the tap list 8,6,5,4: shift left, new bit = XNOR of tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int taps[4] = '{8, 6, 5, 4};
        logic x = 1'b0;
        foreach (taps[i]) x ^= s[taps[i]-1];
        return 8'((int'(s) * 2) % 256 + (x ? 0 : 1));
    endfunction

    function automatic logic [7:0] seed_of(input logic [7:0] s);
        return (s == 8'hFF) ? 8'h00 : s;
    endfunction

    // Walks the LFSR sequence from the first candidate: first in-range value wins, else fallback.
    task automatic predict(input logic [7:0] s0, input int maxt,
                           output int val, output int lat, output logic [7:0] fin);
        logic [7:0] s = s0;
        val = 0; lat = 0; fin = s0;
        for (int i = 0; i < maxt; i++) begin
            if (int'(s) < RNG) begin
                val = int'(s); lat = i + 2; fin = lfsr_next(s);
                return;
            end
            if (i == maxt - 1) begin
                val = int'(s) - RNG; lat = maxt + 1; fin = lfsr_next(s);
                return;
            end
            s = lfsr_next(s);
        end
    endtask

    task automatic do_draw(input logic [7:0] seed, input logic en_req, input string tag);
        logic [7:0] s0, f0, f1;
        int v0, l0, v1, l1;
        int got_l0 = 0, got_l1 = 0, np0 = 0, np1 = 0;
        logic [7:0] gv0 = 8'h00, gv1 = 8'h00;

        SEED_LOAD = 1'b1; SEED_IN = seed; ENABLE = 1'b0;
        tick();
        SEED_LOAD = 1'b0;
        m0 = seed_of(seed); m1 = m0;
        chk({tag, "_seed0"}, 32'(rand0), 32'(m0));
        chk({tag, "_seed1"}, 32'(rand1), 32'(m1));

        s0 = en_req ? lfsr_next(m0) : m0;
        predict(s0, MT0, v0, l0, f0);
        predict(s0, MT1, v1, l1, f1);

        REQ = 1'b1; ENABLE = en_req;
        tick();
        REQ = 1'b0; ENABLE = 1'b0;
        chk({tag, "_busy0"}, 32'(busy0), 32'd1);
        chk({tag, "_busy1"}, 32'(busy1), 32'd1);
        chk({tag, "_hold0"}, 32'(value0), prev_v0);
        chk({tag, "_hold1"}, 32'(value1), prev_v1);

        for (int c = 2; c <= MT0 + 3; c++) begin
            tick();
            if (done0 === 1'b1) begin
                np0++;
                if (got_l0 == 0) begin
                    got_l0 = c; gv0 = value0;
                    chk({tag, "_busyfall0"}, 32'(busy0), 32'd0);
                end
            end else if (got_l0 == 0) begin
                chk({tag, "_busyon0"}, 32'(busy0), 32'd1);
            end
            if (done1 === 1'b1) begin
                np1++;
                if (got_l1 == 0) begin
                    got_l1 = c; gv1 = value1;
                    chk({tag, "_busyfall1"}, 32'(busy1), 32'd0);
                end
            end
        end

        chk({tag, "_lat0"}, got_l0, l0);
        chk({tag, "_lat1"}, got_l1, l1);
        chk({tag, "_val0"}, 32'(gv0), v0);
        chk({tag, "_val1"}, 32'(gv1), v1);
        chk({tag, "_pulses0"}, np0, 1);
        chk({tag, "_pulses1"}, np1, 1);
        chk({tag, "_keep0"}, 32'(value0), v0);
        chk({tag, "_lfsr0"}, 32'(rand0), 32'(f0));
        chk({tag, "_lfsr1"}, 32'(rand1), 32'(f1));
        m0 = f0; m1 = f1;
        prev_v0 = v0; prev_v1 = v1;
        last_v0 = int'(gv0); last_v1 = int'(gv1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first5 [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
        bit seen [256];
        int distinct = 0;
        int saw_ff = 0;
        int np;
        logic sl, en;

        // Reset state
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_rand", 32'(rand0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_value", 32'(value0), 32'd0);
        m0 = 8'h00;

        // Free-run over a full period
        foreach (seen[i]) seen[i] = 1'b0;
        seen[rand0] = 1'b1; distinct = 1;
        ENABLE = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            m0 = lfsr_next(m0);
            if (i < 5) chk("seq_start", 32'(rand0), 32'(first5[i]));
            chk("seq_model", 32'(rand0), 32'(m0));
            if (rand0 == 8'hFF) saw_ff++;
            if (!seen[rand0]) begin seen[rand0] = 1'b1; distinct++; end
        end
        ENABLE = 1'b0;
        chk("seq_distinct", distinct, 255);
        chk("seq_no_ff", saw_ff, 0);
        chk("seq_wrap", 32'(rand0), 32'd0);
        chk("seq_idle_done", 32'(done0), 32'd0);

        // Seed load: lockup value replaced, load beats step
        SEED_LOAD = 1'b1; SEED_IN = 8'hFF;
        tick();
        chk("seed_ff", 32'(rand0), 32'd0);
        SEED_IN = 8'h5A; ENABLE = 1'b1;
        tick();
        chk("seed_5a_en", 32'(rand0), 32'h5A);
        chk("seed_5a_en1", 32'(rand1), 32'h5A);
        SEED_LOAD = 1'b0; ENABLE = 1'b0;

        // Directed draws
        do_draw(8'h10, 1'b0, "d10");
        chk("d10_value", last_v0, 32'h10);
        do_draw(8'hC8, 1'b0, "dc8");
        chk("dc8_fallback1", last_v1, 32'd40);
        do_draw(8'hFF, 1'b0, "dff");
        do_draw(8'hA5, 1'b1, "da5");

        // REQ held while busy is ignored
        SEED_LOAD = 1'b1; SEED_IN = 8'hC8;
        tick();
        SEED_LOAD = 1'b0; REQ = 1'b1;
        tick();
        tick();
        chk("ign_done1", 32'(done1), 32'd1);
        chk("ign_val1", 32'(value1), 32'd40);
        chk("ign_busy0", 32'(busy0), 32'd1);
        REQ = 1'b0;
        tick();
        chk("ign_done0", 32'(done0), 32'd1);
        chk("ign_val0", 32'(value0), 32'd145);
        chk("ign_busy1", 32'(busy1), 32'd0);
        chk("ign_done1b", 32'(done1), 32'd0);
        tick();
        chk("ign_idle0", 32'(busy0), 32'd0);
        chk("ign_idle1", 32'(busy1), 32'd0);
        m0 = lfsr_next(lfsr_next(8'hC8)); m1 = lfsr_next(8'hC8);
        chk("ign_lfsr0", 32'(rand0), 32'(m0));
        chk("ign_lfsr1", 32'(rand1), 32'(m1));

        // REQ in the DONE cycle starts a new draw
        SEED_LOAD = 1'b1; SEED_IN = 8'h10;
        tick();
        SEED_LOAD = 1'b0; REQ = 1'b1;
        tick();
        REQ = 1'b0;
        tick();
        chk("b2b_done", 32'(done0), 32'd1);
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        chk("b2b_busy0", 32'(busy0), 32'd1);
        chk("b2b_busy1", 32'(busy1), 32'd1);
        chk("b2b_hold", 32'(value0), 32'h10);
        chk("b2b_nodone", 32'(done0), 32'd0);
        tick();
        chk("b2b_done2", 32'(done1), 32'd1);
        chk("b2b_val0", 32'(value0), 32'(lfsr_next(8'h10)));
        chk("b2b_val1", 32'(value1), 32'(lfsr_next(8'h10)));
        m0 = lfsr_next(lfsr_next(8'h10)); m1 = m0;
        chk("b2b_lfsr", 32'(rand0), 32'(m0));

        // Seed load during a draw stalls it and the seed becomes the next candidate
        SEED_LOAD = 1'b1; SEED_IN = 8'hC8;
        tick();
        SEED_LOAD = 1'b0; REQ = 1'b1;
        tick();
        REQ = 1'b0; SEED_LOAD = 1'b1; SEED_IN = 8'h10;
        tick();
        SEED_LOAD = 1'b0;
        chk("mid_seed_busy0", 32'(busy0), 32'd1);
        chk("mid_seed_busy1", 32'(busy1), 32'd1);
        chk("mid_seed_nodone1", 32'(done1), 32'd0);
        chk("mid_seed_rand", 32'(rand0), 32'h10);
        tick();
        chk("mid_seed_done1", 32'(done1), 32'd1);
        chk("mid_seed_val0", 32'(value0), 32'h10);
        chk("mid_seed_val1", 32'(value1), 32'h10);
        m0 = lfsr_next(8'h10); m1 = m0;
        chk("mid_seed_lfsr", 32'(rand1), 32'(m1));

        // Reset during a draw
        SEED_LOAD = 1'b1; SEED_IN = 8'hC8;
        tick();
        SEED_LOAD = 1'b0; REQ = 1'b1;
        tick();
        REQ = 1'b0; RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rstmid_busy", 32'(busy0), 32'd0);
        chk("rstmid_value", 32'(value0), 32'd0);
        chk("rstmid_value1", 32'(value1), 32'd0);
        chk("rstmid_rand", 32'(rand0), 32'd0);
        np = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) np++;
        end
        chk("rstmid_nodone", np, 0);
        m0 = 8'h00; m1 = 8'h00; prev_v0 = 0; prev_v1 = 0;

        // Randomized idle traffic and draws
        for (int t = 0; t < 40; t++) begin
            int gap = int'($urandom_range(0, 6));
            for (int g = 0; g < gap; g++) begin
                en = 1'($urandom % 2);
                sl = ($urandom % 8) == 0;
                ENABLE = en; SEED_LOAD = sl; SEED_IN = 8'($urandom);
                tick();
                if (sl) begin
                    m0 = seed_of(SEED_IN); m1 = m0;
                end else if (en) begin
                    m0 = lfsr_next(m0); m1 = lfsr_next(m1);
                end
                chk("rnd_idle0", 32'(rand0), 32'(m0));
                chk("rnd_idle1", 32'(rand1), 32'(m1));
            end
            ENABLE = 1'b0; SEED_LOAD = 1'b0;
            do_draw(8'($urandom), 1'($urandom % 2), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
